// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I issue controller.
// FSM encodings and sizing constants used by the top and scoreboard.
package rv32i_pkg;

  localparam int REG_BITS_DEF     = 5;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Register busy bitmap with set/clear and same-cycle writeback bypass.
// x0 is never tracked; a simultaneous set and clear of one register sets.
module rv32i_scoreboard
  import rv32i_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [REG_BITS-1:0]      set_addr,
  input  logic                     clr_en,
  input  logic [REG_BITS-1:0]      clr_addr,
  input  logic                     flush,
  input  logic [REG_BITS-1:0]      rs1_addr,
  input  logic [REG_BITS-1:0]      rs2_addr,
  output logic [(1<<REG_BITS)-1:0] pending,
  output logic                     rs1_busy,
  output logic                     rs2_busy
);

  localparam int NREG = 1 << REG_BITS;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else pend_q <= pend_d;
  end

  assign pending = pend_q;

  // A register retiring this cycle is already free for the reader.
  assign rs1_busy = pend_q[rs1_addr]
                  & ~(clr_en & (clr_addr == rs1_addr));
  assign rs2_busy = pend_q[rs2_addr]
                  & ~(clr_en & (clr_addr == rs2_addr));

endmodule

// File: rtl/rv32i_issue_ctrl.sv
// Issue controller: RAW hazard stall, in-flight limit and flush drain.
// issue_o is combinational so decode can hand off in the same cycle.
module rv32i_issue_ctrl
  import rv32i_pkg::*;
#(
  parameter int REG_BITS     = REG_BITS_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic                                fetch_valid_i,
  input  logic [REG_BITS-1:0]                 rs1_addr_i,
  input  logic [REG_BITS-1:0]                 rs2_addr_i,
  input  logic [REG_BITS-1:0]                 rd_addr_i,
  input  logic                                uses_rs1_i,
  input  logic                                uses_rs2_i,
  input  logic                                writes_rd_i,
  input  logic                                ex_ready_i,
  input  logic                                retire_i,
  input  logic                                wb_we_i,
  input  logic [REG_BITS-1:0]                 wb_rd_addr_i,
  output logic                                issue_o,
  output logic                                stall_o,
  output logic [1:0]                          state_o,
  output logic [(1<<REG_BITS)-1:0]            pending_o,
  output logic [$clog2(MAX_INFLIGHT):0]       inflight_o,
  output logic                                err_o
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  state_t        state_q;
  logic [CW-1:0] inflight_q;
  logic          err_q;

  logic rs1_busy, rs2_busy;
  logic hazard, full, wb_clr;
  logic retire_ok, retire_bad;
  logic drain_done, set_en;

  assign wb_clr = retire_i & wb_we_i;

  assign hazard = (uses_rs1_i & (rs1_addr_i != '0) & rs1_busy)
                | (uses_rs2_i & (rs2_addr_i != '0) & rs2_busy);

  assign full = (inflight_q == CW'(MAX_INFLIGHT)) & ~retire_i;

  assign issue_o = fetch_valid_i & ex_ready_i & ~hazard & ~full
                 & ~clear_i & (state_q != ST_DRAIN);

  assign stall_o = fetch_valid_i & ~issue_o & ~clear_i;

  assign retire_ok  = retire_i & (inflight_q != '0);
  assign retire_bad = retire_i & (inflight_q == '0);

  assign drain_done = (state_q == ST_DRAIN)
                    & (inflight_q == '0) & ~clear_i;

  assign set_en = issue_o & writes_rd_i & (rd_addr_i != '0);

  rv32i_scoreboard #(
    .REG_BITS (REG_BITS)
  ) u_sb (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .set_en   (set_en),
    .set_addr (rd_addr_i),
    .clr_en   (wb_clr),
    .clr_addr (wb_rd_addr_i),
    .flush    (drain_done),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .pending  (pending_o),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else if (clear_i) begin
      state_q <= ST_DRAIN;
    end else begin
      unique case (state_q)
        ST_RUN:   if (stall_o) state_q <= ST_STALL;
        ST_STALL: if (issue_o | ~fetch_valid_i) state_q <= ST_RUN;
        ST_DRAIN: if (inflight_q == '0) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      unique case (1'b1)
        issue_o & ~retire_ok: inflight_q <= inflight_q + CW'(1);
        retire_ok & ~issue_o: inflight_q <= inflight_q - CW'(1);
        default:              inflight_q <= inflight_q;
      endcase
    end
  end

  // Leaving drain with a busy register means a writeback went missing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else if (retire_bad | (drain_done & (|pending_o))) err_q <= 1'b1;
  end

  assign state_o    = state_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rv32i_issue_ctrl.sv
// Directed bench for rv32i_issue_ctrl with default parameters.
// Inputs change 1ns after the rising edge; outputs are checked before the next.
module tb_rv32i_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        fetch_valid_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        uses_rs1_i, uses_rs2_i, writes_rd_i;
  logic        ex_ready_i;
  logic        retire_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_addr_i;
  logic        issue_o, stall_o;
  logic [1:0]  state_o;
  logic [31:0] pending_o;
  logic [2:0]  inflight_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  rv32i_issue_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .fetch_valid_i (fetch_valid_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rd_addr_i     (rd_addr_i),
    .uses_rs1_i    (uses_rs1_i),
    .uses_rs2_i    (uses_rs2_i),
    .writes_rd_i   (writes_rd_i),
    .ex_ready_i    (ex_ready_i),
    .retire_i      (retire_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .issue_o       (issue_o),
    .stall_o       (stall_o),
    .state_o       (state_o),
    .pending_o     (pending_o),
    .inflight_o    (inflight_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    clear_i = 0; fetch_valid_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
    uses_rs1_i = 0; uses_rs2_i = 0; writes_rd_i = 0;
    retire_i = 0; wb_we_i = 0; wb_rd_addr_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    ex_ready_i = 1;
    idle();
    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pending", pending_o, 32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    tick();
    rst_ni = 1;

    // RAW hazard on x5 and same-cycle writeback bypass
    fetch_valid_i = 1; rd_addr_i = 5; writes_rd_i = 1;
    #1 chk("raw_issue_wr", 32'(issue_o), 32'd1);
    tick();
    chk("raw_pend5", pending_o, 32'h20);
    chk("raw_cnt1", 32'(inflight_o), 32'd1);
    rd_addr_i = 0; writes_rd_i = 0; rs1_addr_i = 5; uses_rs1_i = 1;
    #1 chk("raw_blk_issue", 32'(issue_o), 32'd0);
    chk("raw_blk_stall", 32'(stall_o), 32'd1);
    tick();
    chk("raw_state_stall", 32'(state_o), 32'd1);
    retire_i = 1; wb_we_i = 1; wb_rd_addr_i = 5;
    #1 chk("raw_bypass_issue", 32'(issue_o), 32'd1);
    chk("raw_bypass_stall", 32'(stall_o), 32'd0);
    tick();
    chk("raw_state_run", 32'(state_o), 32'd0);
    chk("raw_pend_clr", pending_o, 32'd0);
    chk("raw_cnt_same", 32'(inflight_o), 32'd1);
    idle(); retire_i = 1;
    tick();
    chk("raw_cnt0", 32'(inflight_o), 32'd0);

    // x0 is never tracked
    idle(); fetch_valid_i = 1; writes_rd_i = 1;
    #1 chk("x0_issue_wr", 32'(issue_o), 32'd1);
    tick();
    chk("x0_pend", pending_o, 32'd0);
    writes_rd_i = 0; uses_rs1_i = 1;
    #1 chk("x0_issue_rd", 32'(issue_o), 32'd1);
    chk("x0_stall", 32'(stall_o), 32'd0);
    tick();
    idle(); retire_i = 1;
    tick();
    tick();
    chk("x0_cnt0", 32'(inflight_o), 32'd0);

    // In-flight limit and retire-enabled fifth issue
    idle(); fetch_valid_i = 1;
    tick(); tick(); tick(); tick();
    chk("full_cnt4", 32'(inflight_o), 32'd4);
    #1 chk("full_blk_issue", 32'(issue_o), 32'd0);
    chk("full_blk_stall", 32'(stall_o), 32'd1);
    retire_i = 1;
    #1 chk("full_ret_issue", 32'(issue_o), 32'd1);
    tick();
    chk("full_cnt_hold", 32'(inflight_o), 32'd4);

    // Set beats clear on the same register
    rd_addr_i = 7; writes_rd_i = 1; wb_we_i = 1; wb_rd_addr_i = 7;
    #1 chk("setclr_issue", 32'(issue_o), 32'd1);
    tick();
    chk("setclr_pend7", pending_o, 32'h80);
    chk("setclr_cnt", 32'(inflight_o), 32'd4);

    // Flush and drain from three outstanding
    idle(); retire_i = 1;
    tick();
    chk("drn_cnt3", 32'(inflight_o), 32'd3);
    idle(); fetch_valid_i = 1; clear_i = 1;
    #1 chk("drn_clr_issue", 32'(issue_o), 32'd0);
    chk("drn_clr_stall", 32'(stall_o), 32'd0);
    tick();
    chk("drn_state", 32'(state_o), 32'd2);
    clear_i = 0; retire_i = 1; wb_we_i = 1; wb_rd_addr_i = 7;
    #1 chk("drn_issue_a", 32'(issue_o), 32'd0);
    chk("drn_stall_a", 32'(stall_o), 32'd1);
    tick();
    chk("drn_cnt2", 32'(inflight_o), 32'd2);
    chk("drn_pend0", pending_o, 32'd0);
    wb_we_i = 0;
    #1 chk("drn_issue_b", 32'(issue_o), 32'd0);
    tick();
    #1 chk("drn_issue_c", 32'(issue_o), 32'd0);
    tick();
    chk("drn_cnt0", 32'(inflight_o), 32'd0);
    chk("drn_state_hold", 32'(state_o), 32'd2);
    idle();
    tick();
    chk("drn_state_run", 32'(state_o), 32'd0);
    chk("drn_err0", 32'(err_o), 32'd0);

    // Spurious retire is sticky
    retire_i = 1;
    tick();
    chk("spur_err", 32'(err_o), 32'd1);
    chk("spur_cnt", 32'(inflight_o), 32'd0);
    retire_i = 0;
    tick();
    chk("spur_err_hold", 32'(err_o), 32'd1);

    // Async reset mid-stall
    fetch_valid_i = 1; rd_addr_i = 9; writes_rd_i = 1;
    tick();
    writes_rd_i = 0; rd_addr_i = 0; rs2_addr_i = 9; uses_rs2_i = 1;
    #1 chk("rs2_blk_issue", 32'(issue_o), 32'd0);
    tick();
    chk("rs2_state_stall", 32'(state_o), 32'd1);
    chk("rs2_pend9", pending_o, 32'h200);
    #2 rst_ni = 0;
    #1 chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_pend", pending_o, 32'd0);
    chk("arst_cnt", 32'(inflight_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    idle();
    tick();
    rst_ni = 1;
    retire_i = 1;
    tick();
    chk("post_rst_err", 32'(err_o), 32'd1);
    idle(); rst_ni = 0;
    tick();
    rst_ni = 1;

    // Drain exit with a stale busy bit clears it and flags an error
    fetch_valid_i = 1; rd_addr_i = 3; writes_rd_i = 1;
    tick();
    idle(); retire_i = 1;
    tick();
    chk("stale_pend3", pending_o, 32'h8);
    chk("stale_cnt0", 32'(inflight_o), 32'd0);
    idle(); clear_i = 1;
    tick();
    chk("stale_drain", 32'(state_o), 32'd2);
    clear_i = 0;
    tick();
    chk("stale_run", 32'(state_o), 32'd0);
    chk("stale_pend_clr", pending_o, 32'd0);
    chk("stale_err", 32'(err_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32i_issue_ctrl.md
RV32I_ISSUE_CTRL -- requirements
Module: rv32i_issue_ctrl

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, register address width.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, maximum issued-but-unretired instructions (power of 2, >=2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i clock and rst_ni reset.
REQ-004 SHALL have ports, each as name  direction  width  meaning:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  async active-low reset.
- clear_i  in  1  pipeline flush request.
- fetch_valid_i  in  1  instruction presented to decode.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_BITS each  fields of the presented instruction.
- uses_rs1_i, uses_rs2_i, writes_rd_i  in  1 each  operand/destination usage flags.
- ex_ready_i  in  1  downstream can accept.
- retire_i  in  1  one issued instruction completes.
- wb_we_i  in  1  retiring instruction writes a register.
- wb_rd_addr_i  in  REG_BITS  retiring destination.
- issue_o  out  1  instruction accepted this cycle; drives decode data_ready_i and fetch ready.
- stall_o  out  1  fetch_valid_i high but not issued.
- state_o  out  2  FSM state.
- pending_o  out  2^REG_BITS  scoreboard bitmap.
- inflight_o  out  log2(MAX_INFLIGHT)+1  outstanding count.
- err_o  out  1  sticky protocol error.

Function
REQ-005 SHALL implement FSM states RUN=0, STALL=1, DRAIN=2; 3 is unreachable and SHALL recover to RUN.
REQ-006 hazard = (uses_rs1_i & rs1!=0 & pending[rs1] & ~wb_clr(rs1)) | same for rs2; wb_clr(r) = retire_i & wb_we_i & wb_rd_addr_i==r (same-cycle writeback bypass).
REQ-007 full = inflight_o==MAX_INFLIGHT & ~retire_i.
REQ-008 issue_o SHALL be combinational: fetch_valid_i & ex_ready_i & ~hazard & ~full & ~clear_i & state_o!=DRAIN; zero-cycle latency.
REQ-009 On issue with writes_rd_i & rd!=0, pending[rd] SHALL set next edge; pending[0] SHALL always read 0.
REQ-010 wb_clr SHALL clear pending[wb_rd_addr_i] next edge; simultaneous set and clear of the same register: set wins.
REQ-011 inflight: +1 on issue, -1 on retire_i, unchanged on both; never exceeds MAX_INFLIGHT.
REQ-012 retire_i with inflight_o==0 SHALL be ignored for the count and set err_o until reset.
REQ-013 Transitions: RUN->STALL when stall_o; STALL->RUN when issue_o or ~fetch_valid_i; any->DRAIN on clear_i; DRAIN->RUN when inflight_o==0 and ~clear_i.
REQ-014 In DRAIN, issue_o SHALL be 0; retirements SHALL continue to update count and scoreboard.
REQ-015 On DRAIN->RUN, pending_o SHALL be 0; a nonzero bit SHALL be cleared and SHALL set err_o.
REQ-016 stall_o = fetch_valid_i & ~issue_o & ~clear_i.

Reset
REQ-017 Reset assertion SHALL immediately force state RUN, pending_o 0, inflight_o 0, err_o 0; issue_o and stall_o follow from inputs.
REQ-018 Reset mid-operation SHALL discard all in-flight tracking; later retire_i SHALL set err_o.

Structure
REQ-019 State encodings, MAX_INFLIGHT default and REG_BITS SHALL live in shared package rv32i_pkg.
REQ-020 The scoreboard (bitmap, set/clear/bypass lookup) SHALL be sub-module rv32i_scoreboard.

Verification
REQ-021 Issue rd=5 writes_rd; next, rs1=5 uses_rs1 -> issue_o=0, stall_o=1, state STALL; retire wb_rd=5 same cycle -> issue_o=1.
REQ-022 Four issues without retire (MAX_INFLIGHT=4) -> inflight_o=4, fifth blocked; retire_i on that cycle -> fifth issues, count stays 4.
REQ-023 rd=0 issued, then rs1=0 read -> pending_o=0, no stall.
REQ-024 inflight 3, clear_i pulse -> DRAIN, issue_o=0 for three retirements, RUN the cycle after count reaches 0.
REQ-025 retire_i with inflight_o=0 -> err_o=1 and held; rst_ni low mid-STALL -> RUN, all counters 0 immediately.
REQ-026 Same-cycle issue rd=7 and retire wb_rd=7 -> pending[7]=1 afterwards.
